// File: rtl/ram_access_sched.sv
// ram_access_sched: round-robin scheduler for two requesters in front of
// the single-port SPI RAM; turns each byte transaction into a cmd pair.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/we/addr/wdata  requester N transaction handshake
//   rspN_valid/rdata/err       requester N completion pulse and result
//   ram_din/ram_rx_valid       command word {op,byte} and its strobe
//   ram_dout/ram_tx_valid      read data returned by the RAM
//   busy                       a transaction is in flight
module ram_access_sched #(
  parameter int RD_TIMEOUT = 4,
  parameter int TMO_W      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_rdata,
  output logic       rsp0_err,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_rdata,
  output logic       rsp1_err,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WAIT_RD,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner_q;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic [TMO_W-1:0] cnt;
  logic             sel0;
  logic             sel1;
  logic             accept;
  logic             tmo_last;
  logic             rsp_load;
  logic [7:0]       rsp_data_nxt;
  logic             rsp_err_nxt;

  // On a tie the requester that did not win last time is selected.
  assign sel0 = req0_valid && (!req1_valid || last_grant);
  assign sel1 = req1_valid && (!req0_valid || !last_grant);

  // rst_n gating keeps ready low while reset is held.
  assign req0_ready = rst_n && (state == S_IDLE) && sel0;
  assign req1_ready = rst_n && (state == S_IDLE) && sel1;
  assign accept     = req0_ready || req1_ready;

  assign tmo_last   = (cnt == TMO_W'(RD_TIMEOUT - 1));
  assign rsp0_valid = (state == S_RESP) && !owner_q;
  assign rsp1_valid = (state == S_RESP) && owner_q;
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt    = state;
    ram_rx_valid = 1'b0;
    ram_din      = 10'h000;
    rsp_load     = 1'b0;
    rsp_data_nxt = 8'h00;
    rsp_err_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {~we_q, 1'b0, addr_q};
        state_nxt    = S_DATA;
      end
      S_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = we_q ? {2'b01, wdata_q}
                            : {2'b11, 8'h00};
        if (we_q) begin
          rsp_load  = 1'b1;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (ram_tx_valid) begin
          rsp_load     = 1'b1;
          rsp_data_nxt = ram_dout;
          state_nxt    = S_RESP;
        end else if (tmo_last) begin
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
          state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
    end else if (accept) begin
      last_grant <= req1_ready;
      owner_q    <= req1_ready;
      we_q       <= req1_ready ? req1_we : req0_we;
      addr_q     <= req1_ready ? req1_addr : req0_addr;
      wdata_q    <= req1_ready ? req1_wdata : req0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_DATA) begin
      cnt <= '0;
    end else if (state == S_WAIT_RD) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers hold until the next completion for that requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_rdata <= 8'h00;
      rsp0_err   <= 1'b0;
      rsp1_rdata <= 8'h00;
      rsp1_err   <= 1'b0;
    end else if (rsp_load) begin
      if (owner_q) begin
        rsp1_rdata <= rsp_data_nxt;
        rsp1_err   <= rsp_err_nxt;
      end else begin
        rsp0_rdata <= rsp_data_nxt;
        rsp0_err   <= rsp_err_nxt;
      end
    end
  end

endmodule
